// File: rtl/dbus_master_if.sv
// dbus_master bus types and the command/response/peripheral port bundle.
// Ports: cmd_* in, rsp_* out, dbus2peri_o / peri2dbus_i, busy_o.
package dbus_pkg;
   localparam int XLEN = 32;

   typedef struct packed {
      logic            req;
      logic            wr;
      logic [3:0]      mask;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] w_data;
   } type_dbus2peri_s;

   typedef struct packed {
      logic [XLEN-1:0] r_data;
      logic            ack;
   } type_peri2dbus_s;
endpackage

interface dbus_master_if;
   import dbus_pkg::*;

   logic            cmd_valid_i;
   logic            cmd_ready_o;
   logic            cmd_wr_i;
   logic [XLEN-1:0] cmd_addr_i;
   logic [XLEN-1:0] cmd_wdata_i;
   logic [3:0]      cmd_mask_i;
   logic            rsp_valid_o;
   logic            rsp_ready_i;
   logic [XLEN-1:0] rsp_rdata_o;
   logic            rsp_err_o;
   type_dbus2peri_s dbus2peri_o;
   type_peri2dbus_s peri2dbus_i;
   logic            busy_o;

   modport master (
      input  cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
      output cmd_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  rsp_ready_i,
      output dbus2peri_o,
      input  peri2dbus_i,
      output busy_o
   );

   modport slave (
      output cmd_valid_i, cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_mask_i,
      input  cmd_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output rsp_ready_i,
      input  dbus2peri_o,
      output peri2dbus_i,
      input  busy_o
   );
endinterface

// File: rtl/dbus_master.sv
// dbus_master: command FIFO feeding a single-outstanding peripheral bus FSM.
// Ports: clk, rst (sync, active high), bus (dbus_master_if.master).
// Optional: DBUS_MASTER_TIMEOUT_EN enables the ACCESS timeout counter.
module dbus_master
   import dbus_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   dbus_master_if.master bus
);

   localparam int PW = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be 1..1023");
   end

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

   typedef struct packed {
      logic            wr;
      logic [3:0]      mask;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
   } cmd_s;

   cmd_s            mem_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW:0]     cnt_q, cnt_d;
   logic            full, push, pop;
   state_e          state_q, state_d;
   type_dbus2peri_s dbus_q, dbus_d;
   logic [XLEN-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            ack;
   logic            tmo_hit;
   cmd_s            head;

   assign ack  = bus.peri2dbus_i.ack;
   assign head = mem_q[rd_ptr_q];

   // Ready comes from the registered count only, so a full FIFO
   // stays closed even on the cycle its head is popped.
   assign full = (cnt_q == (PW+1)'(FIFO_DEPTH));
   assign push = bus.cmd_valid_i && !full;
   assign pop  = (state_q == IDLE) && (cnt_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{wr:    bus.cmd_wr_i,
                              mask:  bus.cmd_mask_i,
                              addr:  bus.cmd_addr_i,
                              wdata: bus.cmd_wdata_i};
      end
   end

`ifdef DBUS_MASTER_TIMEOUT_EN
   logic [9:0] tmo_q, tmo_d;

   // Hit on the edge that ends ACCESS cycle number TIMEOUT_CYCLES.
   assign tmo_hit = ((tmo_q + 10'd1) == 10'(TIMEOUT_CYCLES));

   always_comb begin
      tmo_d = tmo_q;
      if (pop) begin
         tmo_d = '0;
      end else if (state_q == ACCESS && !ack) begin
         tmo_d = tmo_q + 10'd1;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         dbus_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
`ifdef DBUS_MASTER_TIMEOUT_EN
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         dbus_q   <= dbus_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
`ifdef DBUS_MASTER_TIMEOUT_EN
         tmo_q    <= tmo_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pop) state_d = ACCESS;
         ACCESS:  if (ack || tmo_hit) state_d = RESP;
         RESP:    if (bus.rsp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bus fields are loaded once on issue and held until the next issue;
   // ack takes priority over a timeout on the same edge.
   always_comb begin
      dbus_d  = dbus_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (pop) begin
               dbus_d.req    = 1'b1;
               dbus_d.wr     = head.wr;
               dbus_d.mask   = head.mask;
               dbus_d.addr   = head.addr;
               dbus_d.w_data = head.wdata;
            end
         end
         ACCESS: begin
            if (ack) begin
               dbus_d.req = 1'b0;
               rdata_d    = dbus_q.wr ? '0 : bus.peri2dbus_i.r_data;
               err_d      = 1'b0;
            end else if (tmo_hit) begin
               dbus_d.req = 1'b0;
               rdata_d    = '0;
               err_d      = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.cmd_ready_o = !full;
      bus.dbus2peri_o = dbus_q;
      bus.rsp_valid_o = (state_q == RESP);
      bus.rsp_rdata_o = rdata_q;
      bus.rsp_err_o   = err_q;
      bus.busy_o      = (state_q != IDLE) || (cnt_q != '0);
   end

endmodule

// File: tb/tb_dbus_master.sv
// Randomised bench for dbus_master with a transaction-level queue model.
// Directed cases pin latency, fill level, reset and timeout behaviour.
module tb_dbus_master;
   import dbus_pkg::*;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   typedef struct packed {
      logic        wr;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   logic clk = 1'b0;
   logic rst;

   dbus_master_if bus ();

   dbus_master #(
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int hs_cnt = 0;
   bit cmp_en = 0;
   int ack_mode = -2;
   bit fix_en = 0;
   logic [31:0] fix_val = '0;

   cmd_t        mq[$];
   cmd_t        m_cur;
   bit          m_acc, m_rsp, m_err;
   int          m_age;
   logic [31:0] m_rdata;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference: queue of waiting commands, one transaction in flight,
   // one pending response. Ready depends on queue size before the edge.
   always @(posedge clk) begin
      cmd_t c;
      bit   push;
      if (rst) begin
         mq.delete();
         m_cur = '0; m_acc = 0; m_rsp = 0;
         m_err = 0; m_age = 0; m_rdata = '0;
      end else begin
         push = bus.cmd_valid_i && (mq.size() < DEPTH);
         c = '{wr: bus.cmd_wr_i, mask: bus.cmd_mask_i,
               addr: bus.cmd_addr_i, wdata: bus.cmd_wdata_i};
         if (m_rsp) begin
            if (bus.rsp_ready_i) m_rsp = 0;
         end else if (m_acc) begin
            if (bus.peri2dbus_i.ack) begin
               m_acc = 0; m_rsp = 1; m_err = 0;
               m_rdata = m_cur.wr ? 32'h0 : bus.peri2dbus_i.r_data;
`ifdef DBUS_MASTER_TIMEOUT_EN
            end else if (m_age + 1 == TMO) begin
               m_acc = 0; m_rsp = 1; m_err = 1; m_rdata = '0;
`endif
            end else begin
               m_age++;
            end
         end else if (mq.size() > 0) begin
            m_cur = mq.pop_front();
            m_acc = 1; m_age = 0;
         end
         if (push) mq.push_back(c);
      end
   end

   always @(negedge clk) begin
      bus.peri2dbus_i.r_data = fix_en ? fix_val : $urandom;
      if (ack_mode == -1)
         bus.peri2dbus_i.ack = ($urandom % 3 == 0);
      else if (ack_mode == -2)
         bus.peri2dbus_i.ack = 1'b0;
      else
         bus.peri2dbus_i.ack = m_acc && (m_age >= ack_mode);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cmd_ready", bus.cmd_ready_o, mq.size() < DEPTH);
         check("busy", bus.busy_o, m_acc || m_rsp || mq.size() > 0);
         check("req", bus.dbus2peri_o.req, m_acc);
         check("wr", bus.dbus2peri_o.wr, m_cur.wr);
         check("mask", bus.dbus2peri_o.mask, m_cur.mask);
         check("addr", bus.dbus2peri_o.addr, m_cur.addr);
         check("w_data", bus.dbus2peri_o.w_data, m_cur.wdata);
         check("rsp_valid", bus.rsp_valid_o, m_rsp);
         if (m_rsp) begin
            check("rsp_rdata", bus.rsp_rdata_o, m_rdata);
            check("rsp_err", bus.rsp_err_o, m_err);
         end
      end
   end

   // All inputs for the coming edge are set before calling tick.
   task automatic tick();
      if (bus.rsp_valid_o && bus.rsp_ready_i) hs_cnt++;
      @(negedge clk);
   endtask

   task automatic push(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
      int n = 0;
      bus.cmd_wr_i = wr; bus.cmd_addr_i = a;
      bus.cmd_wdata_i = d; bus.cmd_mask_i = m;
      bus.cmd_valid_i = 1'b1;
      while (!bus.cmd_ready_o && n < 100) begin tick(); n++; end
      if (!bus.cmd_ready_o) check("push_ready", bus.cmd_ready_o, 1);
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   task automatic wait_rsp(output int reqs);
      int n = 0;
      reqs = 0;
      while (!bus.rsp_valid_o && n < 60) begin
         if (bus.dbus2peri_o.req) reqs++;
         tick(); n++;
      end
      if (!bus.rsp_valid_o) check("rsp_wait", bus.rsp_valid_o, 1);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!bus.dbus2peri_o.req && n < 20) begin tick(); n++; end
      if (!bus.dbus2peri_o.req) check("req_wait", bus.dbus2peri_o.req, 1);
   endtask

   task automatic drain();
      int n = 0;
      bus.cmd_valid_i = 1'b0;
      bus.rsp_ready_i = 1'b1;
      while ((bus.busy_o || bus.rsp_valid_o) && n < 500) begin tick(); n++; end
      if (bus.busy_o) check("drain_busy", bus.busy_o, 0);
   endtask

   initial begin
      int reqs, pushed, cyc, hs0;
      bit acc;
      rst = 1'b1;
      bus.cmd_valid_i = 0; bus.cmd_wr_i = 0; bus.cmd_addr_i = '0;
      bus.cmd_wdata_i = '0; bus.cmd_mask_i = '0; bus.rsp_ready_i = 0;
      bus.peri2dbus_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      cmp_en = 1;
      check("rst_ready", bus.cmd_ready_o, 1);
      check("rst_busy", bus.busy_o, 0);
      check("rst_req", bus.dbus2peri_o.req, 0);
      check("rst_addr", bus.dbus2peri_o.addr, 0);
      check("rst_rsp_valid", bus.rsp_valid_o, 0);
      check("rst_rdata", bus.rsp_rdata_o, 0);
      check("rst_err", bus.rsp_err_o, 0);
      rst = 1'b0;
      tick();

      // Read with ack in the fourth request cycle.
      ack_mode = 3; fix_en = 1; fix_val = 32'hA5; bus.rsp_ready_i = 1;
      push(0, 32'h10, 32'h0, 4'hF);
      wait_rsp(reqs);
      check("rd_req_cycles", reqs, 4);
      check("rd_rdata", bus.rsp_rdata_o, 32'hA5);
      check("rd_err", bus.rsp_err_o, 0);
      tick();
      fix_en = 0;

      // Write acked in its first request cycle.
      ack_mode = 0;
      push(1, 32'h4, 32'h3C, 4'h1);
      wait_req();
      check("wr_wr", bus.dbus2peri_o.wr, 1);
      check("wr_wdata", bus.dbus2peri_o.w_data, 32'h3C);
      check("wr_mask", bus.dbus2peri_o.mask, 4'h1);
      check("wr_addr", bus.dbus2peri_o.addr, 32'h4);
      wait_rsp(reqs);
      check("wr_req_cycles", reqs, 1);
      check("wr_rdata", bus.rsp_rdata_o, 0);
      check("wr_err", bus.rsp_err_o, 0);
      tick();

      // One stalled access, then fill the FIFO behind it.
      ack_mode = -2; bus.rsp_ready_i = 0;
      hs0 = hs_cnt;
      push(0, 32'h100, 32'h0, 4'hF);
      wait_req();
      pushed = 0; cyc = 0;
      while (pushed < 5 && cyc < 200) begin
         bus.cmd_wr_i = 0; bus.cmd_addr_i = 32'h200 + 32'(pushed * 4);
         bus.cmd_wdata_i = $urandom; bus.cmd_mask_i = 4'hF;
         bus.cmd_valid_i = 1;
         acc = bus.cmd_ready_o;
         if (pushed == 4 && ack_mode == -2) begin
            check("full_after_4", bus.cmd_ready_o, 0);
            ack_mode = 0; bus.rsp_ready_i = 1;
         end
         tick();
         if (acc) pushed++;
         cyc++;
      end
      check("fill_pushed", pushed, 5);
      drain();
      check("fill_responses", hs_cnt - hs0, 6);

      // Reset in the middle of an access with two commands queued.
      ack_mode = -2; bus.rsp_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         bus.cmd_wr_i = 0; bus.cmd_addr_i = 32'h300 + 32'(i);
         bus.cmd_wdata_i = '0; bus.cmd_mask_i = 4'hF;
         bus.cmd_valid_i = 1;
         tick();
      end
      bus.cmd_valid_i = 0;
      check("pre_rst_req", bus.dbus2peri_o.req, 1);
      rst = 1; tick(); rst = 0;
      check("post_rst_req", bus.dbus2peri_o.req, 0);
      check("post_rst_busy", bus.busy_o, 0);
      hs0 = hs_cnt;
      bus.rsp_ready_i = 1; ack_mode = -1;
      repeat (10) tick();
      check("post_rst_no_rsp", hs_cnt - hs0, 0);
      push(0, 32'h400, 32'h0, 4'hF);
      drain();
      check("post_rst_one_rsp", hs_cnt - hs0, 1);

`ifdef DBUS_MASTER_TIMEOUT_EN
      ack_mode = -2;
      push(0, 32'h500, 32'h0, 4'hF);
      wait_rsp(reqs);
      check("tmo_req_cycles", reqs, 8);
      check("tmo_err", bus.rsp_err_o, 1);
      check("tmo_rdata", bus.rsp_rdata_o, 0);
      tick();
      ack_mode = 7;
      push(0, 32'h504, 32'h0, 4'hF);
      wait_rsp(reqs);
      check("tmo_ack_req_cycles", reqs, 8);
      check("tmo_ack_err", bus.rsp_err_o, 0);
      tick();
`endif

      // Random traffic, random ack, random back-pressure, rare resets.
      ack_mode = -1;
      for (int i = 0; i < 600; i++) begin
         bus.cmd_valid_i = ($urandom % 2 == 0);
         bus.cmd_wr_i = $urandom;
         bus.cmd_addr_i = $urandom;
         bus.cmd_wdata_i = $urandom;
         bus.cmd_mask_i = 4'($urandom);
         bus.rsp_ready_i = ($urandom % 4 != 0);
         rst = ($urandom % 250 == 0);
         tick();
      end
      rst = 0;
      drain();
      check("end_idle_busy", bus.busy_o, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
